// File: rtl/spi_txn_arbiter_if.sv
// rtl/spi_txn_arbiter_if.sv - request, response and SPI master signal bundle for spi_txn_arbiter
interface spi_txn_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_data;
    logic [8*N_REQ-1:0]  req_ss;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_data;
    logic                rsp_err;
    logic                spi_start;
    logic [31:0]         spi_din;
    logic [7:0]          spi_sel;
    logic                spi_busy;
    logic [31:0]         spi_dout;

    modport master (
        input  req_valid, req_data, req_ss, rsp_ready, spi_busy, spi_dout,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, spi_start, spi_din, spi_sel
    );

    modport slave (
        output req_valid, req_data, req_ss, rsp_ready, spi_busy, spi_dout,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, spi_start, spi_din, spi_sel
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter sequencing one shared 32-bit SPI master
module spi_txn_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int GAP_CYC     = 2
) (
    input  logic              clk,
    input  logic              reset,
    spi_txn_arbiter_if.master bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW   = $clog2(TIMEOUT_CYC + 1);
    localparam int GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    // Two short: the timer starts one cycle after the pulse and the error registers one edge later.
    localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 2);
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [ID_W-1:0] ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP,
        S_GAP
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [ID_W-1:0]   id_q, id_nxt;
    logic [31:0]       data_q, data_nxt;
    logic              err_q, err_nxt;
    logic [31:0]       din_q, din_nxt;
    logic [7:0]        sel_q, sel_nxt;
    logic [TW-1:0]     timer_q, timer_nxt;
    logic [GW-1:0]     gap_q, gap_nxt;
    logic [N_REQ-1:0]  ready_c;
    logic              start_c;
    logic              rsp_valid_c;
    logic              grant;
    logic              found_hi;
    logic [ID_W-1:0]   win, win_hi, win_lo;
    logic [31:0]       win_data;
    logic [7:0]        win_ss;

    // win_hi: lowest requester at or above the pointer; win_lo: lowest overall, used on wrap.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win_lo = ID_W'(i);
                if (i >= int'(ptr)) begin
                    win_hi   = ID_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win      = found_hi ? win_hi : win_lo;
        win_data = bus.req_data[32*int'(win) +: 32];
        win_ss   = bus.req_ss[8*int'(win) +: 8];
    end

    assign grant = (state == S_IDLE) && (|bus.req_valid) && !bus.spi_busy && !reset;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        id_nxt      = id_q;
        data_nxt    = data_q;
        err_nxt     = err_q;
        din_nxt     = din_q;
        sel_nxt     = sel_q;
        timer_nxt   = timer_q;
        gap_nxt     = gap_q;
        ready_c     = '0;
        start_c     = 1'b0;
        rsp_valid_c = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (grant) begin
                    ready_c[win] = 1'b1;
                    din_nxt      = win_data;
                    sel_nxt      = win_ss;
                    id_nxt       = win;
                    if (win_ss == 8'hFF) begin
                        err_nxt   = 1'b1;
                        data_nxt  = 32'h0;
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                start_c   = 1'b1;
                timer_nxt = '0;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                timer_nxt = timer_q + 1'b1;
                if (timer_q == TO_LAST) begin
                    err_nxt   = 1'b1;
                    data_nxt  = 32'h0;
                    state_nxt = S_RESP;
                end else if (bus.spi_busy) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                timer_nxt = timer_q + 1'b1;
                if (!bus.spi_busy) begin
                    err_nxt   = 1'b0;
                    data_nxt  = bus.spi_dout;
                    state_nxt = S_RESP;
                end else if (timer_q == TO_LAST) begin
                    err_nxt   = 1'b1;
                    data_nxt  = 32'h0;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    sel_nxt   = 8'hFF;
                    ptr_nxt   = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
                    gap_nxt   = '0;
                    state_nxt = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_q + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            id_q    <= '0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
            din_q   <= 32'h0;
            sel_q   <= 8'hFF;
            timer_q <= '0;
            gap_q   <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            id_q    <= id_nxt;
            data_q  <= data_nxt;
            err_q   <= err_nxt;
            din_q   <= din_nxt;
            sel_q   <= sel_nxt;
            timer_q <= timer_nxt;
            gap_q   <= gap_nxt;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.spi_start = start_c;
    assign bus.spi_din   = din_q;
    assign bus.spi_sel   = sel_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - self-checking bench for spi_txn_arbiter with an SPI master model
module tb_spi_txn_arbiter;
    localparam int N_REQ       = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int GAP_CYC     = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [7:0]  ss;
        logic [31:0] miso;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_txn_arbiter_if #(.N_REQ(N_REQ)) bus ();

    spi_txn_arbiter #(
        .N_REQ      (N_REQ),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC    (GAP_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   start_cnt = 0;
    int   start_cyc = 0;
    rsp_t sb_q[$];
    int   gq[$];
    rsp_t mon_e;
    int   mon_idx;

    logic        slave_stuck, slave_force, slave_echo;
    logic [31:0] slave_miso;
    logic        busy_q;
    logic [4:0]  bit_cnt;
    logic [31:0] dout_q;

    assign bus.spi_busy = busy_q;
    assign bus.spi_dout = dout_q;

    // SPI master model: busy one cycle after start, 32 busy cycles, MISO word ready at fall.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            bit_cnt <= 5'd0;
            dout_q  <= 32'h0;
        end else if (slave_force) begin
            busy_q  <= 1'b1;
            bit_cnt <= 5'd0;
        end else if (bus.spi_start && !slave_stuck) begin
            busy_q  <= 1'b1;
            bit_cnt <= 5'd31;
            dout_q  <= slave_echo ? ~bus.spi_din : slave_miso;
        end else if (busy_q) begin
            if (bit_cnt == 5'd0) busy_q <= 1'b0;
            else                 bit_cnt <= bit_cnt - 5'd1;
        end
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expire(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, awaited event never seen", name);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                expire("rsp_unexpected");
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
                check("rsp_data", bus.rsp_data, mon_e.data);
                check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            end
        end
        if (!reset && bus.req_ready != '0) begin
            check("grant_onehot", 32'($countones(bus.req_ready)), 32'd1);
            mon_idx = -1;
            for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) mon_idx = i;
            if (gq.size() == 0) expire("grant_unexpected");
            else check("grant_idx", 32'(mon_idx), 32'(gq.pop_front()));
        end
        if (!reset && bus.spi_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input logic [31:0] data, input logic [7:0] ss, output int gcyc);
        bus.req_data[32*id +: 32] = data;
        bus.req_ss[8*id +: 8]     = ss;
        bus.req_valid[id]         = 1'b1;
        gcyc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) expire("grant_wait");
        tick();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int rcyc);
        rcyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                rcyc = cyc;
                break;
            end
        end
        if (rcyc < 0) expire("rsp_wait");
    endtask

    task automatic wait_sb_empty();
        for (int k = 0; k < 400 && sb_q.size() != 0; k++) tick();
        if (sb_q.size() != 0) expire("sb_drain");
    endtask

    task automatic wait_busy_high();
        for (int k = 0; k < 10 && !bus.spi_busy; k++) tick();
        if (!bus.spi_busy) expire("busy_rise");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        vecs[4];
    logic [31:0] rr_data[4];
    logic [7:0]  rr_ss[4];
    int          g, r, s0, cnt, found;

    initial begin
        vecs[0] = '{1, 32'hA5A5_0F0F, 8'hFE, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[1] = '{2, 32'hCAFE_BABE, 8'hFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        vecs[2] = '{0, 32'h0000_0000, 8'h7F, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
        vecs[3] = '{3, 32'hFFFF_FFFF, 8'h00, 32'h0000_0000, 1'b0, 32'h0000_0000};
        rr_data = '{32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0, 32'h8000_0001};
        rr_ss   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};

        slave_stuck   = 1'b0;
        slave_force   = 1'b0;
        slave_echo    = 1'b0;
        slave_miso    = 32'h0;
        bus.rsp_ready = 1'b1;
        bus.req_data  = {4{32'hDEAD_BEEF}};
        bus.req_ss    = {4{8'h00}};
        bus.req_valid = 4'hF;
        reset         = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'h0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("reset_rsp_data", bus.rsp_data, 32'h0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        check("reset_spi_start", 32'(bus.spi_start), 32'h0);
        check("reset_spi_din", bus.spi_din, 32'h0);
        check("reset_spi_sel", 32'(bus.spi_sel), 32'hFF);
        tick();
        bus.req_valid = '0;
        reset = 1'b0;
        tick();

        // Single-requester transfers, including the invalid-select path.
        for (int v = 0; v < 4; v++) begin
            slave_miso = vecs[v].miso;
            s0 = start_cnt;
            sb_q.push_back('{2'(vecs[v].id), vecs[v].exp_data, vecs[v].exp_err});
            gq.push_back(vecs[v].id);
            issue(vecs[v].id, vecs[v].data, vecs[v].ss, g);
            if (vecs[v].ss != 8'hFF) begin
                wait_busy_high();
                check("xfer_sel", 32'(bus.spi_sel), 32'(vecs[v].ss));
                check("xfer_din", bus.spi_din, vecs[v].data);
            end
            wait_rsp(r);
            if (vecs[v].ss == 8'hFF) check("lat_badsel", 32'(r - g), 32'd1);
            else check("lat_le_36", 32'((r - g) >= 34 && (r - g) <= 36), 32'd1);
            wait_sb_empty();
            check("start_pulses", 32'(start_cnt - s0), (vecs[v].ss == 8'hFF) ? 32'd0 : 32'd1);
        end

        // All requesters valid: grants rotate 0,1,2,3,0 with select idle between transfers.
        slave_echo = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back('{2'(k % 4), ~rr_data[k % 4], 1'b0});
            gq.push_back(k % 4);
        end
        for (int i = 0; i < 4; i++) begin
            bus.req_data[32*i +: 32] = rr_data[i];
            bus.req_ss[8*i +: 8]     = rr_ss[i];
        end
        bus.req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            found = 0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (bus.rsp_valid && bus.rsp_ready) begin
                    found = 1;
                    break;
                end
            end
            if (found == 0) expire("rr_rsp_wait");
            if (k < 4) begin
                cnt = 0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (bus.spi_sel != 8'hFF) break;
                    cnt++;
                end
                check("gap_sel_idle_ge_gap", 32'(cnt >= GAP_CYC), 32'd1);
            end
            if (k == 3) begin
                tick();
                bus.req_valid = '0;
            end
        end
        wait_sb_empty();
        check("rr_grants_drained", 32'(gq.size()), 32'd0);

        // Response back-pressure: outputs hold and no further grant while rsp_ready is low.
        slave_echo    = 1'b0;
        slave_miso    = 32'h0F1E_2D3C;
        bus.rsp_ready = 1'b0;
        sb_q.push_back('{2'd2, 32'h0F1E_2D3C, 1'b0});
        sb_q.push_back('{2'd1, 32'h0BEE_F001, 1'b0});
        gq.push_back(2);
        gq.push_back(1);
        issue(2, 32'h7777_0000, 8'hBF, g);
        bus.req_data[32 +: 32] = 32'h0000_1111;
        bus.req_ss[8 +: 8]     = 8'hDF;
        bus.req_valid[1]       = 1'b1;
        wait_rsp(r);
        for (int t = 0; t < 10; t++) begin
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_data", bus.rsp_data, 32'h0F1E_2D3C);
            check("hold_no_grant", 32'(bus.req_ready), 32'h0);
            @(negedge clk);
        end
        tick();
        slave_miso    = 32'h0BEE_F001;
        bus.rsp_ready = 1'b1;
        found = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.req_ready[1]) begin
                found = 1;
                break;
            end
        end
        if (found == 0) expire("grant1_wait");
        tick();
        bus.req_valid[1] = 1'b0;
        wait_sb_empty();

        // Timeout with busy stuck low, then a busy master blocks new grants.
        slave_stuck = 1'b1;
        sb_q.push_back('{2'd3, 32'h0, 1'b1});
        gq.push_back(3);
        issue(3, 32'h1234_0000, 8'hEF, g);
        wait_rsp(r);
        check("timeout_cycles", 32'(r - start_cyc), 32'(TIMEOUT_CYC));
        tick();
        slave_stuck = 1'b0;
        slave_force = 1'b1;
        slave_miso  = 32'h600D_CAFE;
        bus.req_data[0 +: 32] = 32'h4444_4444;
        bus.req_ss[0 +: 8]    = 8'hFE;
        bus.req_valid[0]      = 1'b1;
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.req_ready != '0) cnt++;
        end
        check("no_grant_while_busy", 32'(cnt), 32'd0);
        tick();
        sb_q.push_back('{2'd0, 32'h600D_CAFE, 1'b0});
        gq.push_back(0);
        slave_force = 1'b0;
        issue(0, 32'h4444_4444, 8'hFE, g);
        wait_sb_empty();

        // Reset in WAIT_DONE aborts at once; the pointer restarts at requester 0.
        gq.push_back(2);
        issue(2, 32'h5A5A_5A5A, 8'hFE, g);
        wait_busy_high();
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check("abort_spi_sel", 32'(bus.spi_sel), 32'hFF);
        check("abort_spi_start", 32'(bus.spi_start), 32'h0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        slave_miso = 32'hFACE_0000;
        sb_q.push_back('{2'd0, 32'hFACE_0000, 1'b0});
        gq.push_back(0);
        bus.req_valid = 4'hF;
        found = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) found = i;
                break;
            end
        end
        if (found < 0) expire("post_reset_grant_wait");
        else check("post_reset_grant", 32'(found), 32'd0);
        tick();
        bus.req_valid = '0;
        wait_sb_empty();

        check("sb_empty_end", 32'(sb_q.size()), 32'd0);
        check("gq_empty_end", 32'(gq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
